id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the 5-stage pipelined MIPS core.
- Sits directly upstream of the ALU. Registers decoded ID-stage operands and controls, then resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU's in1, in2, ALUCtl and Sign inputs, and flags load-use hazards back to the hazard/PC logic.

Parameters:
- DW, 32, datapath width.
- AW, 5, register-address width.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold all EX-stage registers
- flush  in  1  load a bubble on next edge
- ID_PC  in  DW  PC+4 of ID instruction
- ID_RsData, ID_RtData  in  DW each  register-file read data
- ID_Imm  in  DW  extended immediate
- ID_Shamt  in  5  shift amount
- ID_Rs, ID_Rt, ID_Rd  in  AW each  register addresses
- ID_ALUCtl  in  6  ALU operation code
- ID_Sign  in  1  signed compare select
- ID_ALUSrc1  in  1  1: in1 = zero-extended shamt
- ID_ALUSrc2  in  1  1: in2 = immediate
- ID_RegDst  in  2  00 rt, 01 rd, 10 $31
- ID_RegWrite, ID_MemRead, ID_MemWrite  in  1 each  controls
- ID_MemToReg  in  2  writeback select
- MEM_RegWrite  in  1  EX/MEM write enable
- MEM_Dest  in  AW  EX/MEM destination
- MEM_Data  in  DW  EX/MEM ALU result
- WB_RegWrite  in  1  MEM/WB write enable
- WB_Dest  in  AW  MEM/WB destination
- WB_Data  in  DW  MEM/WB writeback data
- ALU_in1, ALU_in2  out  DW each  ALU operands
- ALU_Ctl  out  6  to ALU ALUCtl
- ALU_Sign  out  1  to ALU Sign
- EX_StoreData  out  DW  forwarded rt value for sw
- EX_Dest  out  AW  resolved destination register
- EX_PC  out  DW  registered PC+4
- EX_RegWrite, EX_MemRead, EX_MemWrite  out  1 each  registered controls
- EX_MemToReg  out  2  registered controls
- LoadUse  out  1  load-use hazard request to stall IF/ID

Behaviour:
- Reset (reset=0, async): every register clears to 0. All registered outputs therefore read 0, EX_Dest=0, ALU_Ctl=6'b000000, and LoadUse=0.
- Edge update priority, highest first: reset > flush > stall > capture.
  - flush=1: load a bubble. RegWrite, MemRead and MemWrite go to 0, ALU_Ctl goes to 0, Dest goes to 0; data registers clear to 0.
  - stall=1 (flush=0): all registers hold.
  - Otherwise: capture all ID_* inputs.
  - flush and stall both 1: flush wins.
- Dest is resolved at capture. RegDst 00 gives ID_Rt, 01 gives ID_Rd, 10 gives 5'd31, 11 gives 0.
- ALU_Ctl, ALU_Sign and all EX_* outputs are direct register outputs. Latency from ID input to output is 1 cycle.
- Forwarding is combinational from registered Rs/Rt and the MEM/WB inputs, applied independently to rs and rt:
  - Use MEM_Data if MEM_RegWrite && MEM_Dest!=0 && MEM_Dest==reg.
  - Else use WB_Data if WB_RegWrite && WB_Dest!=0 && WB_Dest==reg.
  - Else use the registered value.
  - EX/MEM has priority over MEM/WB when both match.
  - $0 is never forwarded.
- Operand selection:
  - ALU_in1 = ALUSrc1 ? {27'b0, Shamt} : fwd_rs.
  - ALU_in2 = ALUSrc2 ? Imm : fwd_rt.
  - EX_StoreData = fwd_rt, always, independent of ALUSrc2.
- Hazard: LoadUse = EX_MemRead && EX_Dest!=0 && (EX_Dest==ID_Rs || EX_Dest==ID_Rt). It is combinational and reflects the current register state.
- Stalled cycle: forwarding keeps tracking the live MEM/WB inputs, so operands may change while registers hold.
- Reset asserted mid-operation clears state immediately, without waiting for clk.

Test Plan:
- Reset, then deassert with no capture -> all outputs 0, LoadUse=0.
- Capture add: RsData=5, RtData=7, ALUCtl=000000, RegDst=01, Rd=3, no hazard -> next cycle ALU_in1=5, ALU_in2=7, EX_Dest=3, EX_RegWrite=1.
- Double forward: EX Rs=Rt=8; MEM_RegWrite=1, MEM_Dest=8, MEM_Data=0xAA; WB_RegWrite=1, WB_Dest=8, WB_Data=0xBB -> ALU_in1=ALU_in2=0xAA. Repeat with MEM_RegWrite=0 -> 0xBB. Repeat with Dest=0 -> registered values.
- Shift and immediate: ALUSrc1=1, Shamt=4, ALUSrc2=1, Imm=0xFFFF_FFF0, RtData=9 with rt forwarding active (MEM_Data=0x55) -> ALU_in1=4, ALU_in2=0xFFFF_FFF0, EX_StoreData=0x55.
- Load-use: lw captured with RegDst=00, Rt=6; next ID_Rs=6 -> LoadUse=1. Assert stall for one cycle -> registers hold. Then flush -> EX_MemRead=0, EX_RegWrite=0, LoadUse=0.
- flush=1 and stall=1 same edge -> bubble loaded. Async reset pulse between edges -> outputs 0 immediately. jal with RegDst=10 -> EX_Dest=31.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding for the
// 5-stage MIPS core; also raises the load-use hazard toward the IF/ID logic.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic [DW-1:0] ID_PC,
   input  logic [DW-1:0] ID_RsData,
   input  logic [DW-1:0] ID_RtData,
   input  logic [DW-1:0] ID_Imm,
   input  logic [4:0]    ID_Shamt,
   input  logic [AW-1:0] ID_Rs,
   input  logic [AW-1:0] ID_Rt,
   input  logic [AW-1:0] ID_Rd,
   input  logic [5:0]    ID_ALUCtl,
   input  logic          ID_Sign,
   input  logic          ID_ALUSrc1,
   input  logic          ID_ALUSrc2,
   input  logic [1:0]    ID_RegDst,
   input  logic          ID_RegWrite,
   input  logic          ID_MemRead,
   input  logic          ID_MemWrite,
   input  logic [1:0]    ID_MemToReg,
   input  logic          MEM_RegWrite,
   input  logic [AW-1:0] MEM_Dest,
   input  logic [DW-1:0] MEM_Data,
   input  logic          WB_RegWrite,
   input  logic [AW-1:0] WB_Dest,
   input  logic [DW-1:0] WB_Data,
   output logic [DW-1:0] ALU_in1,
   output logic [DW-1:0] ALU_in2,
   output logic [5:0]    ALU_Ctl,
   output logic          ALU_Sign,
   output logic [DW-1:0] EX_StoreData,
   output logic [AW-1:0] EX_Dest,
   output logic [DW-1:0] EX_PC,
   output logic          EX_RegWrite,
   output logic          EX_MemRead,
   output logic          EX_MemWrite,
   output logic [1:0]    EX_MemToReg,
   output logic          LoadUse
);

   typedef struct packed {
      logic [DW-1:0] pc;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [DW-1:0] imm;
      logic [4:0]    shamt;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] dest;
      logic [5:0]    alu_ctl;
      logic          sign;
      logic          alu_src1;
      logic          alu_src2;
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
      logic [1:0]    mem_to_reg;
   } ex_reg_t;

   ex_reg_t       id_d;
   ex_reg_t       ex_q;
   logic [DW-1:0] fwd_rs;
   logic [DW-1:0] fwd_rt;

   // NOTE: every field gets a value before the case, so no path can infer a latch.
   always_comb begin
      id_d            = '0;
      id_d.pc         = ID_PC;
      id_d.rs_data    = ID_RsData;
      id_d.rt_data    = ID_RtData;
      id_d.imm        = ID_Imm;
      id_d.shamt      = ID_Shamt;
      id_d.rs         = ID_Rs;
      id_d.rt         = ID_Rt;
      id_d.alu_ctl    = ID_ALUCtl;
      id_d.sign       = ID_Sign;
      id_d.alu_src1   = ID_ALUSrc1;
      id_d.alu_src2   = ID_ALUSrc2;
      id_d.reg_write  = ID_RegWrite;
      id_d.mem_read   = ID_MemRead;
      id_d.mem_write  = ID_MemWrite;
      id_d.mem_to_reg = ID_MemToReg;
      case (ID_RegDst)
         2'b00:   id_d.dest = ID_Rt;
         2'b01:   id_d.dest = ID_Rd;
         2'b10:   id_d.dest = AW'(31);
         default: id_d.dest = '0;
      endcase
   end

   // A bubble is simply the all-zero record: no writes, no memory access, ALU op 0.
   // NOTE: non-blocking assignments so the register samples pre-edge values only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      ex_q <= '0;
      else if (flush)  ex_q <= '0;
      else if (!stall) ex_q <= id_d;
   end

   // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
   always_comb begin
      fwd_rs = ex_q.rs_data;
      if (MEM_RegWrite && MEM_Dest != '0 && MEM_Dest == ex_q.rs)
         fwd_rs = MEM_Data;
      else if (WB_RegWrite && WB_Dest != '0 && WB_Dest == ex_q.rs)
         fwd_rs = WB_Data;

      fwd_rt = ex_q.rt_data;
      if (MEM_RegWrite && MEM_Dest != '0 && MEM_Dest == ex_q.rt)
         fwd_rt = MEM_Data;
      else if (WB_RegWrite && WB_Dest != '0 && WB_Dest == ex_q.rt)
         fwd_rt = WB_Data;
   end

   assign ALU_in1      = ex_q.alu_src1 ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_rs;
   assign ALU_in2      = ex_q.alu_src2 ? ex_q.imm : fwd_rt;
   assign EX_StoreData = fwd_rt;
   assign ALU_Ctl      = ex_q.alu_ctl;
   assign ALU_Sign     = ex_q.sign;
   assign EX_Dest      = ex_q.dest;
   assign EX_PC        = ex_q.pc;
   assign EX_RegWrite  = ex_q.reg_write;
   assign EX_MemRead   = ex_q.mem_read;
   assign EX_MemWrite  = ex_q.mem_write;
   assign EX_MemToReg  = ex_q.mem_to_reg;

   assign LoadUse = ex_q.mem_read && (ex_q.dest != '0) &&
                    ((ex_q.dest == ID_Rs) || (ex_q.dest == ID_Rt));

endmodule
